// File: rtl/input_cond_pkg.sv
// Shared types and helpers for the operator input conditioner.
package input_cond_pkg;

    // Per-button hold state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } btn_state_t;

    // Counter width for a counter holding values 0..n-1, never below 1 bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One input channel: synchroniser, tick-based debouncer, press/hold FSM.
module button_channel
    import input_cond_pkg::*;
#(
    parameter int DEB_TICKS  = 4,
    parameter int LONG_TICKS = 200
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic tick_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o
);

    localparam int DW = cnt_w(DEB_TICKS + 1);
    localparam int HW = cnt_w(LONG_TICKS + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);

    logic          sync1_q, sync2_q;
    logic [DW-1:0] deb_q, deb_d;
    logic          level_q, level_d;
    logic          press_q, release_q, long_q;
    logic          press_d, release_d, long_d;
    logic [HW-1:0] hold_q, hold_d;
    btn_state_t    state_q, state_d;

    logic differ, flip, count_en;

    assign differ   = (sync2_q != level_q);
    // The tick that completes qualification flips the level.
    assign flip     = tick_i && differ && (deb_q == DEB_LAST);
    // A tick that drops the level does not also count toward a long press.
    assign count_en = tick_i && level_q && !flip;

    // Two-flop synchroniser for the raw pin.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count ticks where the sample disagrees with the level.
    always_comb begin
        deb_d     = deb_q;
        level_d   = level_q;
        if (tick_i) begin
            if (!differ) begin
                deb_d = '0;
            end else if (deb_q == DEB_LAST) begin
                deb_d   = '0;
                level_d = ~level_q;
            end else begin
                deb_d = deb_q + 1'b1;
            end
        end
        press_d   = flip && !level_q;
        release_d = flip &&  level_q;
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (press_q) state_d = HELD;
            HELD: begin
                if (!level_q)                                state_d = IDLE;
                else if (count_en && (hold_q == HOLD_LAST))  state_d = LONG;
            end
            LONG: if (!level_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: long-press pulse and saturating hold counter.
    always_comb begin
        long_d = (state_q == HELD) && count_en && (hold_q == HOLD_LAST);
        hold_d = hold_q;
        if (state_q == IDLE)
            hold_d = '0;
        else if ((state_q == HELD) && count_en && (hold_q != HOLD_MAX))
            hold_d = hold_q + 1'b1;
    end

    // Registered level, counters and event pulses.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            deb_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            hold_q    <= '0;
        end else begin
            deb_q     <= deb_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            hold_q    <= hold_d;
        end
    end

    assign level_o      = level_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_q;

endmodule

// File: rtl/input_conditioner.sv
// Operator input front end: shared tick prescaler plus N_CH button channels.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int N_CH       = 5,
    parameter int CLK_DIV    = 50000,
    parameter int DEB_TICKS  = 4,
    parameter int LONG_TICKS = 200
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [N_CH-1:0] in_btn_i,
    output logic            tick_o,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] long_press_o
);

    localparam int PW = cnt_w(CLK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic          tick_q;

    // Prescaler wraps at CLK_DIV-1.
    always_comb begin
        pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    end

    // Registered tick, high the cycle after the prescaler hits its last count.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= (pre_q == PRE_LAST);
        end
    end

    assign tick_o = tick_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        button_channel #(
            .DEB_TICKS  (DEB_TICKS),
            .LONG_TICKS (LONG_TICKS)
        ) u_ch (
            .clk_i        (clk_i),
            .reset_i      (reset_i),
            .tick_i       (tick_q),
            .btn_i        (in_btn_i[g]),
            .level_o      (level_o[g]),
            .press_o      (press_o[g]),
            .release_o    (release_o[g]),
            .long_press_o (long_press_o[g])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner (N_CH=2, CLK_DIV=4, DEB=3, LONG=8).
module tb_input_conditioner;

    localparam int N_CH = 2;

    logic            clk_i    = 1'b0;
    logic            reset_i  = 1'b1;
    logic [N_CH-1:0] in_btn_i = '0;
    logic            tick_o;
    logic [N_CH-1:0] level_o, press_o, release_o, long_press_o;

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    int p_cnt [N_CH];
    int r_cnt [N_CH];
    int l_cnt [N_CH];

    input_conditioner #(
        .N_CH(N_CH), .CLK_DIV(4), .DEB_TICKS(3), .LONG_TICKS(8)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .in_btn_i     (in_btn_i),
        .tick_o       (tick_o),
        .level_o      (level_o),
        .press_o      (press_o),
        .release_o    (release_o),
        .long_press_o (long_press_o)
    );

    always #5 clk_i = ~clk_i;

    // Edge count since reset deassert; edge 1 is the first after deassert.
    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Event counters sampled mid-cycle.
    always @(negedge clk_i) begin
        for (int i = 0; i < N_CH; i++) begin
            if (press_o[i])      p_cnt[i] = p_cnt[i] + 1;
            if (release_o[i])    r_cnt[i] = r_cnt[i] + 1;
            if (long_press_o[i]) l_cnt[i] = l_cnt[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance to the negedge following edge number c.
    task automatic goto(input int c);
        int n = 0;
        while (cyc < c && n < 5000) begin
            @(negedge clk_i);
            n++;
        end
        if (cyc != c) check("goto_timeout", cyc, c);
    endtask

    initial begin
        for (int i = 0; i < N_CH; i++) begin
            p_cnt[i] = 0; r_cnt[i] = 0; l_cnt[i] = 0;
        end

        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_tick",  {31'd0, tick_o}, 0);
        check("rst_level", {30'd0, level_o}, 0);
        check("rst_press", {30'd0, press_o}, 0);
        check("rst_rel",   {30'd0, release_o}, 0);
        check("rst_long",  {30'd0, long_press_o}, 0);
        reset_i = 1'b0;

        // Prescaler: tick at 4, 8, 12
        for (int k = 1; k <= 12; k++) begin
            goto(k);
            check($sformatf("tick_c%0d", k), {31'd0, tick_o}, (k % 4 == 0) ? 1 : 0);
        end
        check("idle_level", {30'd0, level_o}, 0);

        // Clean press raised right after the tick at 12
        in_btn_i[0] = 1'b1;
        goto(24);
        check("pre_press_level", {30'd0, level_o}, 2'b00);
        check("pre_press_press", {30'd0, press_o}, 2'b00);
        goto(25);
        check("press_pulse", {30'd0, press_o}, 2'b01);
        check("press_level", {30'd0, level_o}, 2'b01);
        goto(26);
        check("press_width", {30'd0, press_o}, 2'b00);

        // Long press: 8 ticks after press at 25
        goto(56);
        check("long_early", {30'd0, long_press_o}, 2'b00);
        goto(57);
        check("long_pulse", {30'd0, long_press_o}, 2'b01);
        goto(58);
        check("long_width", {30'd0, long_press_o}, 2'b00);

        // Drop at 73 -> release after 2 clk + 3 ticks
        goto(73);
        in_btn_i[0] = 1'b0;
        goto(84);
        check("pre_rel_level", {30'd0, level_o}, 2'b01);
        goto(85);
        check("rel_pulse", {30'd0, release_o}, 2'b01);
        check("rel_level", {30'd0, level_o}, 2'b00);
        #2;
        check("long_once", l_cnt[0], 1);
        check("press_once", p_cnt[0], 1);
        check("rel_once", r_cnt[0], 1);

        // Bounce: toggle every 5 clk for 60 cycles
        begin
            logic seen;
            seen = 1'b0;
            goto(88);
            in_btn_i[0] = 1'b1;
            for (int s = 0; s < 12; s++) begin
                repeat (5) begin
                    @(negedge clk_i);
                    seen = seen | level_o[0];
                end
                if (s < 11) in_btn_i[0] = ~in_btn_i[0];
            end
            in_btn_i[0] = 1'b0;
            goto(168);
            seen = seen | level_o[0];
            check("bounce_level", {31'd0, seen}, 0);
        end
        #2;
        check("bounce_press", p_cnt[0], 1);
        check("bounce_rel", r_cnt[0], 1);

        // Simultaneous channels raised at 168
        goto(168);
        in_btn_i = 2'b11;
        goto(180);
        check("sim_pre", {30'd0, press_o}, 2'b00);
        goto(181);
        check("sim_press", {30'd0, press_o}, 2'b11);
        check("sim_level", {30'd0, level_o}, 2'b11);
        goto(184);
        in_btn_i = 2'b01;
        goto(197);
        check("sim_rel", {30'd0, release_o}, 2'b10);
        check("sim_rel_level", {30'd0, level_o}, 2'b01);

        // Reset while channel 0 is held
        goto(200);
        check("mid_level", {30'd0, level_o}, 2'b01);
        #2;
        reset_i = 1'b1;
        #1;
        check("async_level", {30'd0, level_o}, 2'b00);
        check("async_tick",  {31'd0, tick_o}, 0);
        check("async_press", {30'd0, press_o}, 2'b00);
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        goto(12);
        check("rearm_pre", {30'd0, press_o}, 2'b00);
        check("rearm_lvl0", {30'd0, level_o}, 2'b00);
        goto(13);
        check("rearm_press", {30'd0, press_o}, 2'b01);
        check("rearm_level", {30'd0, level_o}, 2'b01);
        goto(14);
        check("rearm_width", {30'd0, press_o}, 2'b00);
        #2;
        check("tot_press0", p_cnt[0], 3);
        check("tot_press1", p_cnt[1], 1);
        check("tot_rel0", r_cnt[0], 1);
        check("tot_rel1", r_cnt[1], 1);
        check("tot_long0", l_cnt[0], 1);
        check("tot_long1", l_cnt[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Parametrised front end for all operator inputs of the washing-machine controller. It does four things:
- Generates a slow clock-enable tick from `clk`. This replaces a divided clock, so all downstream logic stays on `clk`.
- Synchronises `N_CH` raw button and switch inputs.
- Debounces each input in tick units.
- Emits per-channel press, release and long-press event pulses.

It sits between the board pins and the control FSM. It generalises the former fixed five-input synchroniser stage.

## Interface
Parameters:
- `N_CH`, 5, number of input channels (≥1).
- `CLK_DIV`, 50000, `clk` cycles per tick (≥2).
- `DEB_TICKS`, 4, consecutive ticks of a stable new value needed to accept a change (≥1).
- `LONG_TICKS`, 200, ticks the debounced level must stay high after a press before `long_press` fires (≥1).

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: asynchronous, active-high reset.
- `in_btn` in `N_CH`: raw asynchronous inputs.
- `tick` out 1: one-`clk` pulse every `CLK_DIV` cycles.
- `level` out `N_CH`: debounced level.
- `press` out `N_CH`: one-cycle pulse on a debounced 0→1 change.
- `release` out `N_CH`: one-cycle pulse on a debounced 1→0 change.
- `long_press` out `N_CH`: one-cycle pulse, at most once per press.

## Operation
- **Synchroniser:** two flops per channel on `clk`, giving `sync[i]`.
- **Prescaler:**
  - Counter runs 0..`CLK_DIV`-1 and wraps.
  - `tick` is registered and is high in the cycle after the counter equals `CLK_DIV`-1.
  - Width is `$clog2(CLK_DIV)`.
- **Debounce counter** (per channel, `$clog2(DEB_TICKS+1)` bits):
  - Acts only in cycles where `tick`=1.
  - If `sync[i]` ≠ `level[i]`, increment.
  - If `sync[i]` = `level[i]`, clear to 0.
  - When the increment would reach `DEB_TICKS`: invert `level[i]`, clear the counter, and raise `press` or `release` accordingly.
  - A sample that equals `level[i]` restarts qualification; ticks need not be contiguous in any other sense.
- **Per-channel FSM:**
  - IDLE: when `level` rises → HELD, clear the hold counter.
  - HELD: on each tick with `level`=1, the hold counter increments. When it reaches `LONG_TICKS`, pulse `long_press` → LONG. When `level` falls → IDLE.
  - LONG: when `level` falls → IDLE. No further `long_press` is raised.
  - Hold counter is `$clog2(LONG_TICKS+1)` bits and saturates; it never wraps.
- **Release:** `release` fires from both HELD and LONG.
- **Channel independence:** simultaneous events on different channels are independent and may pulse in the same cycle.
- **Reset:**
  - While `reset` is asserted: all counters, synchroniser flops and outputs are 0, and the FSM is in IDLE.
  - An input held through reset is re-debounced after reset deasserts and produces a fresh `press`.

## Timing
- **Reset values:** `tick`, `level`, `press`, `release`, `long_press` are all 0.
- **First tick:** `tick` first rises in cycle `CLK_DIV` after reset deassert (cycle 1 = the first edge).
- **Input latency:** 2 `clk` for the synchroniser, then `DEB_TICKS` ticks.
- **Level and press/release timing:** `level` changes, and `press`/`release` pulse, in the cycle after the qualifying tick. The pulses are exactly one cycle wide.
- **Long press timing:** `long_press` pulses in the cycle after the `LONG_TICKS`-th tick counted in HELD.
- **Pulse ordering:** `press` and `long_press` never coincide on one channel. Neither do `long_press` and `release`; a tick that drops `level` takes priority over the long-press count.

## Structure
- **Package `input_cond_pkg`:**
  - `btn_state_t` enum {IDLE, HELD, LONG}.
  - Helper function for counter widths.
- **Sub-module `button_channel`:**
  - Contents: synchroniser, debounce counter, FSM and hold counter for one channel.
  - Inputs: `clk`, `reset`, `tick`, raw bit.
  - Instanced `N_CH` times in a generate loop.
- **Top level:** holds only the prescaler and the generate loop.

## Test plan
Bench parameters: `N_CH`=2, `CLK_DIV`=4, `DEB_TICKS`=3, `LONG_TICKS`=8.
1. **Reset/prescaler:** release reset with inputs low → all outputs 0; `tick` at cycles 4, 8, 12…; no events.
2. **Clean press:** raise `in_btn[0]` just after a tick and hold → `level[0]`=1 and a single `press[0]` one cycle after the 3rd subsequent tick; `release[0]` stays 0.
3. **Bounce:** toggle `in_btn[0]` every 5 `clk` for 60 cycles → `level[0]` stays 0; no `press`/`release`.
4. **Long press:** hold `in_btn[0]` for 12 ticks past `press` → exactly one `long_press[0]`, 8 ticks after `press`. Then drop the input → `release[0]` 3 ticks later, with no second `long_press`.
5. **Simultaneous channels:** raise both channels in the same cycle → `press[0]` and `press[1]` in the same cycle. Drop only channel 1 → only `release[1]`.
6. **Reset mid-hold:** assert `reset` while channel 0 is in HELD, holding the input high → outputs clear asynchronously. After deassert → fresh `press[0]` after 2 `clk` plus 3 ticks.
